instruction_fetch_decode: RTL

INSTRUCTION_FETCH_DECODE -- requirements
Module: instruction_fetch_decode

---
 rtl/instruction_fetch_decode_if.sv | 30 +++
 rtl/instruction_fetch_decode.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_decode_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_decode_if
// Instruction-memory fetch bus between the fetch/decode controller and the
// instruction memory.
//   imem_req   : fetch request (controller -> memory)
//   imem_addr  : 10-bit fetch address, equal to the controller's PC
//   imem_ack   : imem_rdata is valid this cycle (memory -> controller)
//   imem_rdata : 16-bit fetched instruction word
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface instruction_fetch_decode_if;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_decode.sv
// ---------------------------------------------------------------------------
// instruction_fetch_decode
// Multi-cycle fetch/decode controller for a 16-bit instruction set with a
// 10-bit program counter. Fetches one instruction per FETCH, decodes it for a
// single cycle, optionally spends two MEM cycles on loads/stores, and stops
// for good on HALT.
//
// Ports:
//   clk                  : clock, all state on the rising edge
//   rst                  : asynchronous, active-high reset
//   imem                 : fetch bus (master modport): req/addr out, ack/rdata in
//   id2, id1, id0        : opcode bits IR[15:13]
//   aluControlSignal     : ALU operation (DECODE of ALU)
//   registerWriteSignal  : register write (DECODE of ALU/LD, last MEM cycle of LD)
//   dataMemoryReadSignal : data memory read (DECODE and MEM of LD)
//   isStore              : store in progress (DECODE and MEM of ST)
//   writeMemorySignal    : data memory write (MEM of ST)
//   pcReadSignal         : jump taken (DECODE of JMP)
//   clockCounterEnabled  : multi-cycle memory access in progress (MEM)
//   halted               : HALT executed; only rst leaves this state
//
// Every output is a flop: the next-cycle value is computed from the next
// state, so the controls become visible in the same cycle the state does.
// ---------------------------------------------------------------------------
module instruction_fetch_decode (
    input  logic                              clk,
    input  logic                              rst,
    instruction_fetch_decode_if.master        imem,
    output logic                              id2,
    output logic                              id1,
    output logic                              id0,
    output logic                              aluControlSignal,
    output logic                              registerWriteSignal,
    output logic                              dataMemoryReadSignal,
    output logic                              isStore,
    output logic                              writeMemorySignal,
    output logic                              pcReadSignal,
    output logic                              clockCounterEnabled,
    output logic                              halted
);

    localparam int INSTR_W = 16;
    localparam int PC_W    = 10;

    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_ST   = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_MEM    = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 req_q, req_d;
    logic                 alu_q, alu_d;
    logic                 rws_q, rws_d;
    logic                 dmr_q, dmr_d;
    logic                 st_q, st_d;
    logic                 wms_q, wms_d;
    logic                 pcr_q, pcr_d;
    logic                 cce_q, cce_d;
    logic                 halted_q, halted_d;
    logic [2:0]           op_q, op_d;

    assign op_q = ir_q[15:13];
    assign op_d = ir_d[15:13];

    // IR[12:10] is carried in the instruction register but no decode uses it.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[12:10];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        req_d    = 1'b0;
        alu_d    = 1'b0;
        rws_d    = 1'b0;
        dmr_d    = 1'b0;
        st_d     = 1'b0;
        wms_d    = 1'b0;
        pcr_d    = 1'b0;
        cce_d    = 1'b0;
        halted_d = 1'b0;

        // Next-state and architectural-state updates.
        case (state_q)
            S_FETCH: begin
                // An ack is only honoured once the request is actually on the
                // bus (the cycle right after reset has req low).
                if (imem.imem_ack && req_q) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op_q)
                    OP_LD, OP_ST: begin
                        cnt_d   = 2'd2;
                        state_d = S_MEM;
                    end
                    OP_JMP: begin
                        // 10-bit add: the offset is two's complement and the
                        // sum wraps modulo 1024.
                        pc_d    = pc_q + ir_q[PC_W-1:0];
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        pc_d    = pc_q + 10'd1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    pc_d    = pc_q + 10'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // Registered outputs for the state being entered.
        case (state_d)
            S_FETCH: begin
                req_d = 1'b1;
            end
            S_DECODE: begin
                case (op_d)
                    OP_ALU: begin
                        alu_d = 1'b1;
                        rws_d = 1'b1;
                    end
                    OP_LD: begin
                        dmr_d = 1'b1;
                        rws_d = 1'b1;
                    end
                    OP_ST: begin
                        st_d = 1'b1;
                    end
                    OP_JMP: begin
                        pcr_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                cce_d = 1'b1;
                if (op_d == OP_LD) begin
                    dmr_d = 1'b1;
                    // Register write-back only on the final MEM cycle.
                    rws_d = (cnt_d == 2'd1);
                end
                if (op_d == OP_ST) begin
                    st_d  = 1'b1;
                    wms_d = 1'b1;
                end
            end
            default: begin
                halted_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            alu_q    <= 1'b0;
            rws_q    <= 1'b0;
            dmr_q    <= 1'b0;
            st_q     <= 1'b0;
            wms_q    <= 1'b0;
            pcr_q    <= 1'b0;
            cce_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            alu_q    <= alu_d;
            rws_q    <= rws_d;
            dmr_q    <= dmr_d;
            st_q     <= st_d;
            wms_q    <= wms_d;
            pcr_q    <= pcr_d;
            cce_q    <= cce_d;
            halted_q <= halted_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;

    assign id2 = op_q[2];
    assign id1 = op_q[1];
    assign id0 = op_q[0];

    assign aluControlSignal     = alu_q;
    assign registerWriteSignal  = rws_q;
    assign dataMemoryReadSignal = dmr_q;
    assign isStore              = st_q;
    assign writeMemorySignal    = wms_q;
    assign pcReadSignal         = pcr_q;
    assign clockCounterEnabled  = cce_q;
    assign halted               = halted_q;

endmodule
